ultrasonic_scan: RTL and testbench
==================================

// Module: ultrasonic_scan
// PURPOSE
//  Round-robin sequencer for four HC-SR04-style ultrasonic rangers (front-1, front-2, left, right).
//  It triggers one sensor at a time, times the echo pulse in microseconds on clk_1M and converts it to cm.
//  It holds the four 12-bit distances that feed the obstacle/turn FSM directly (fd1, fd2, ld, rd).
//  Sensors are fired one at a time so one sensor's echo cannot corrupt another's reading.
// PARAMETERS
//  TRIG_US     10     trigger pulse width, clk_1M cycles
//  TIMEOUT_US  30000  max cycles from trigger fall to echo fall before declaring "no echo"
//  GAP_US      10000  idle cycles after each measurement before firing the next sensor
//  US_PER_CM   58     echo microseconds per cm of range
//  DIST_W      12     distance width; DIST_MAX = 2**DIST_W-1 = 4095
// PORTS
//  clk_1M     in   1   1 MHz system clock; 1 cycle = 1 us
//  rst        in   1   synchronous, active-high reset
//  echo       in   4   raw sensor echo lines, asynchronous; [0]=fd1 [1]=fd2 [2]=ld [3]=rd
//  trig       out  4   sensor trigger lines, same bit mapping; at most one bit high at any time
//  fd1        out  12  front-1 distance, cm
//  fd2        out  12  front-2 distance, cm
//  ld         out  12  left distance, cm
//  rd         out  12  right distance, cm
//  timeout    out  4   per-sensor flag: last measurement timed out; sticky until that sensor's next store
//  scan_done  out  1   1-cycle pulse in the cycle after rd is stored
// BEHAVIOUR
//  Reset values
//   - On clk_1M edge with rst=1: trig=0, timeout=0, scan_done=0.
//   - fd1/fd2/ld/rd=DIST_MAX, so downstream sees "clear" until the first real reading.
//   - sel=0, FSM=TRIG, all counters=0.
//  Echo input
//   - Each echo bit passes through a 2-flop synchronizer, then a registered copy for edge detect.
//   - Echo-to-FSM latency is 2 cycles.
//  FSM states: TRIG, WAIT_RISE, MEASURE, STORE, GAP
//   - TRIG: trig[sel]=1 for exactly TRIG_US cycles -> WAIT_RISE. us_cnt and cm_cnt are cleared.
//   - WAIT_RISE: us_cnt increments each cycle.
//       Synced echo[sel] rising edge (0->1) -> MEASURE.
//       A level already high on entry is not a rise.
//       us_cnt==TIMEOUT_US-1 -> STORE with timeout.
//   - MEASURE: us_cnt and sub_cnt increment each cycle.
//       sub_cnt wraps at US_PER_CM-1; cm_cnt+1 on each wrap.
//       cm_cnt saturates at DIST_MAX.
//       Synced echo falling edge -> STORE.
//       us_cnt==TIMEOUT_US-1 -> STORE with timeout. Timeout wins if both occur in the same cycle.
//   - STORE (1 cycle):
//       Normal: dist[sel]<=cm_cnt (floor(echo_us/US_PER_CM)), timeout[sel]<=0.
//       Timeout: dist[sel]<=DIST_MAX, timeout[sel]<=1.
//       Other distances hold. If sel==3, scan_done=1 on the next cycle.
//   - GAP: wait GAP_US cycles, then sel<=sel+1 (wraps 3->0) -> TRIG.
//  Width rules
//   - us_cnt 15 bits; sub_cnt 6 bits; cm_cnt DIST_W bits.
//   - All comparisons are unsigned.
//  Boundary conditions
//   - Echo pulse shorter than US_PER_CM -> 0 cm.
//   - Echo glitch on a non-selected channel: ignored.
//   - Echo still high when GAP ends: the next TRIG proceeds; the stale level is ignored per the rising-edge rule.
//   - rst mid-operation: restarts at sel=0; all outputs return to reset values on the same edge.
//  Outputs are registered. No combinational path from echo to any output.
// STRUCTURE
//  Shared package ultrasonic_pkg:
//   - state encoding (3-bit localparams)
//   - sensor index constants: S_FD1=0, S_FD2=1, S_LD=2, S_RD=3
//   - DIST_MAX
//  One sub-module, echo_sync:
//   - 2-flop synchronizer plus rise/fall pulse outputs
//   - instantiated 4x, or once on a muxed line
//  Distances held in a 4-entry register array and fanned out to the four named ports.
// TESTING
//  1. Reset for 3 cycles -> trig=0, fd1=fd2=ld=rd=4095, timeout=0, scan_done=0; first trig[0] pulse is 10 cycles wide.
//  2. Echo[0] high 5800 us after trig fall -> fd1=100, timeout[0]=0, fd2/ld/rd stay 4095.
//  3. Echo[0] never rises -> 30000 cycles after trig fall: fd1=4095, timeout[0]=1; trig[1] fires after GAP_US.
//  4. Full scan with echo widths 1160/2900/5800/11600 us -> fd1=20, fd2=50, ld=100, rd=200.
//     scan_done pulses exactly once, 1 cycle after rd updates.
//  5. Echo widths 57 us and 59 us -> 0 cm and 1 cm (floor).
//     Echo held high past timeout -> 4095 with timeout set.
//  6. rst asserted 2000 cycles into MEASURE on sensor 2 -> next cycle trig=0, all distances 4095.
//     Measurement restarts at trig[0]; assert trig is one-hot or zero throughout.

Source files
------------

// File: rtl/ultrasonic_pkg.sv
// Shared types and constants for the ultrasonic ranger sequencer:
// sensor indices, FSM state encoding and the distance range.
package ultrasonic_pkg;

  localparam int DIST_W    = 12;
  localparam int N_SENSORS = 4;

  typedef logic [DIST_W-1:0] dist_t;
  typedef logic [1:0]        sensor_t;

  localparam dist_t DIST_MAX = '1;

  localparam sensor_t S_FD1 = 2'd0;
  localparam sensor_t S_FD2 = 2'd1;
  localparam sensor_t S_LD  = 2'd2;
  localparam sensor_t S_RD  = 2'd3;

  typedef enum logic [2:0] {
    ST_TRIG      = 3'd0,
    ST_WAIT_RISE = 3'd1,
    ST_MEASURE   = 3'd2,
    ST_STORE     = 3'd3,
    ST_GAP       = 3'd4
  } state_t;

  function automatic logic [N_SENSORS-1:0] sensor_onehot(sensor_t s);
    return 4'b0001 << s;
  endfunction

endpackage

// File: rtl/ultrasonic_scan_if.sv
// Sensor-side bundle of the ranger sequencer: raw echo lines in,
// trigger lines, four distances and status flags out.
interface ultrasonic_scan_if;
  import ultrasonic_pkg::*;

  logic [N_SENSORS-1:0] echo;
  logic [N_SENSORS-1:0] trig;
  dist_t                fd1;
  dist_t                fd2;
  dist_t                ld;
  dist_t                rd;
  logic [N_SENSORS-1:0] timeout;
  logic                 scan_done;

  modport master (output echo, input trig, fd1, fd2, ld, rd, timeout, scan_done);
  modport slave  (input echo, output trig, fd1, fd2, ld, rd, timeout, scan_done);

endinterface

// File: rtl/echo_sync.sv
// Two-flop synchronizer for one asynchronous echo line, plus a registered
// copy that yields single-cycle rise and fall pulses.
module echo_sync (
  input  logic clk_1M,
  input  logic rst,
  input  logic echo,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // NOTE: every stage updates with <=, so each flop samples the previous stage's old value and the chain is truly three registers deep.
  always_ff @(posedge clk_1M) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= echo;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/ultrasonic_scan.sv
// Round-robin sequencer for four HC-SR04-style rangers: fires one trigger at
// a time, times the echo on the 1 MHz clock and keeps a distance per sensor.
module ultrasonic_scan
  import ultrasonic_pkg::*;
#(
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30000,
  parameter int GAP_US     = 10000,
  parameter int US_PER_CM  = 58
) (
  input logic               clk_1M,
  input logic               rst,
  ultrasonic_scan_if.slave  bus
);

  localparam int PH_MAX = (GAP_US > TRIG_US) ? GAP_US : TRIG_US;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  localparam logic [PH_W-1:0] TRIG_LAST    = PH_W'(TRIG_US - 1);
  localparam logic [PH_W-1:0] GAP_LAST     = PH_W'(GAP_US - 1);
  localparam logic [14:0]     TIMEOUT_LAST = 15'(TIMEOUT_US - 1);
  localparam logic [5:0]      SUB_LAST     = 6'(US_PER_CM - 1);

  state_t               state_q, state_d;
  sensor_t              sel_q;
  logic [PH_W-1:0]      phase_cnt;
  logic [14:0]          us_cnt;
  logic [5:0]           sub_cnt;
  dist_t                cm_cnt;
  logic                 expired_q;
  dist_t                dist_q [N_SENSORS];
  logic [N_SENSORS-1:0] timeout_q;
  logic [N_SENSORS-1:0] trig_q, trig_d;
  logic                 scan_done_q, scan_done_d;

  logic [N_SENSORS-1:0] rise_v, fall_v;
  logic                 echo_rise, echo_fall, us_expired;

  for (genvar i = 0; i < N_SENSORS; i++) begin : g_sync
    echo_sync u_sync (
      .clk_1M (clk_1M),
      .rst    (rst),
      .echo   (bus.echo[i]),
      .rise   (rise_v[i]),
      .fall   (fall_v[i])
    );
  end

  // Only the selected channel's edges reach the FSM; other lines are ignored.
  assign echo_rise  = rise_v[sel_q];
  assign echo_fall  = fall_v[sel_q];
  assign us_expired = (us_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk_1M) begin
    if (rst) state_q <= ST_TRIG;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_TRIG:      if (phase_cnt == TRIG_LAST) state_d = ST_WAIT_RISE;
      ST_WAIT_RISE: begin
        if (us_expired)     state_d = ST_STORE;
        else if (echo_rise) state_d = ST_MEASURE;
      end
      ST_MEASURE:   if (us_expired || echo_fall) state_d = ST_STORE;
      ST_STORE:     state_d = ST_GAP;
      ST_GAP:       if (phase_cnt == GAP_LAST) state_d = ST_TRIG;
      default:      state_d = ST_TRIG;
    endcase
  end

  // scan_done fires on the first GAP cycle, i.e. the cycle after rd is stored.
  always_comb begin
    trig_d      = (state_q == ST_TRIG) ? sensor_onehot(sel_q) : '0;
    scan_done_d = (state_q == ST_GAP) && (phase_cnt == '0) && (sel_q == S_RD);
  end

  // NOTE: the distance table is four flop words rather than a RAM, so it can and must take a reset value: DIST_MAX reads as "clear".
  always_ff @(posedge clk_1M) begin
    if (rst) begin
      sel_q       <= S_FD1;
      phase_cnt   <= '0;
      us_cnt      <= '0;
      sub_cnt     <= '0;
      cm_cnt      <= '0;
      expired_q   <= 1'b0;
      timeout_q   <= '0;
      trig_q      <= '0;
      scan_done_q <= 1'b0;
      for (int i = 0; i < N_SENSORS; i++) dist_q[i] <= DIST_MAX;
    end else begin
      trig_q      <= trig_d;
      scan_done_q <= scan_done_d;
      unique case (state_q)
        ST_TRIG: begin
          us_cnt    <= '0;
          sub_cnt   <= '0;
          cm_cnt    <= '0;
          expired_q <= 1'b0;
          phase_cnt <= (phase_cnt == TRIG_LAST) ? '0 : phase_cnt + 1'b1;
        end
        ST_WAIT_RISE: begin
          us_cnt <= us_cnt + 1'b1;
          if (us_expired) expired_q <= 1'b1;
        end
        ST_MEASURE: begin
          us_cnt <= us_cnt + 1'b1;
          if (us_expired) expired_q <= 1'b1;
          if (sub_cnt == SUB_LAST) begin
            sub_cnt <= '0;
            if (cm_cnt != DIST_MAX) cm_cnt <= cm_cnt + 1'b1;
          end else begin
            sub_cnt <= sub_cnt + 1'b1;
          end
        end
        ST_STORE: begin
          dist_q[sel_q]    <= expired_q ? DIST_MAX : cm_cnt;
          timeout_q[sel_q] <= expired_q;
        end
        ST_GAP: begin
          if (phase_cnt == GAP_LAST) begin
            phase_cnt <= '0;
            sel_q     <= sel_q + 2'd1;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.trig      = trig_q;
  assign bus.timeout   = timeout_q;
  assign bus.scan_done = scan_done_q;
  assign bus.fd1       = dist_q[S_FD1];
  assign bus.fd2       = dist_q[S_FD2];
  assign bus.ld        = dist_q[S_LD];
  assign bus.rd        = dist_q[S_RD];

endmodule

// File: tb/tb_ultrasonic_scan.sv
// Self-checking bench for ultrasonic_scan: echo stimulus is scheduled from a
// timing model of each measurement slot, and every output is compared each cycle.
module tb_ultrasonic_scan;
  import ultrasonic_pkg::*;

  localparam int TRIG_US    = 10;
  localparam int TIMEOUT_US = 12000;
  localparam int GAP_US     = 200;
  localparam int US_PER_CM  = 58;
  localparam int MAX_ERR    = 50;

  typedef enum int {K_PULSE, K_NONE, K_HOLD} kind_e;
  typedef struct {
    kind_e kind;
    int    a;       // echo rise, cycles after trig fall
    int    w;       // echo width in us
    bit    stale;   // echo already high when the slot starts, drops at t+100
    bit    glitch;  // short pulse on a non-selected channel
    int    rst_at;  // assert rst this many cycles after trig fall (0 = never)
    int    lit_cm;  // hand-computed distance, -1 = none
    int    lit_to;  // hand-computed timeout flag, -1 = none
  } slot_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ultrasonic_scan_if bus ();

  ultrasonic_scan #(
    .TRIG_US    (TRIG_US),
    .TIMEOUT_US (TIMEOUT_US),
    .GAP_US     (GAP_US),
    .US_PER_CM  (US_PER_CM)
  ) dut (
    .clk_1M (clk),
    .rst    (rst),
    .bus    (bus.slave)
  );

  logic [3:0] exp_trig, exp_to;
  int         exp_dist [4];
  logic       exp_done;
  bit         cmp_en = 0;
  int         checks = 0;
  int         errors = 0;
  bit         summary_done = 0;

  task automatic finish_run();
    if (!summary_done) begin
      summary_done = 1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  endtask

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      if (errors >= MAX_ERR) finish_run();
    end
  endtask

  function automatic logic [11:0] dist_port(int s);
    case (s)
      0:       return bus.fd1;
      1:       return bus.fd2;
      2:       return bus.ld;
      default: return bus.rd;
    endcase
  endfunction

  function automatic slot_t mk(kind_e kind, int a, int w, bit stale, bit glitch,
                               int rst_at, int lit_cm, int lit_to);
    slot_t sl;
    sl.kind = kind; sl.a = a; sl.w = w; sl.stale = stale; sl.glitch = glitch;
    sl.rst_at = rst_at; sl.lit_cm = lit_cm; sl.lit_to = lit_to;
    return sl;
  endfunction

  function automatic slot_t rnd_slot();
    int  a, w;
    bit  stale;
    a     = int'($urandom_range(300, 1));
    w     = ($urandom_range(1, 0) == 1) ? int'($urandom_range(120, 1)) : int'($urandom_range(1500, 121));
    stale = (a >= 150) && ($urandom_range(1, 0) == 1);
    return mk(K_PULSE, a, w, stale, bit'($urandom_range(1, 0)), 0, -1, -1);
  endfunction

  // A slot yields a real reading only if the echo fall reaches the FSM before the timeout cycle.
  function automatic bit slot_timed_out(slot_t sl);
    return !(sl.kind == K_PULSE && sl.a + sl.w <= TIMEOUT_US - 5);
  endfunction

  // Cycle at which the distance register takes its new value (t = trig fall cycle).
  function automatic int store_cycle(slot_t sl, int t);
    return slot_timed_out(sl) ? t + TIMEOUT_US : t + sl.a + sl.w + 4;
  endfunction

  function automatic int expected_cm(slot_t sl);
    int cm;
    if (slot_timed_out(sl)) return int'(DIST_MAX);
    cm = sl.w / US_PER_CM;
    return (cm > int'(DIST_MAX)) ? int'(DIST_MAX) : cm;
  endfunction

  function automatic logic [3:0] echo_for(slot_t sl, int s, int t, int k);
    logic [3:0] e;
    int         r;
    e = '0;
    r = t + sl.a;
    case (sl.kind)
      K_PULSE: e[s] = (k >= r) && (k < r + sl.w);
      K_HOLD:  e[s] = (k >= r);
      default: ;
    endcase
    if (sl.stale && k < t + 100) e[s] = 1'b1;
    if (sl.glitch && k >= r + 5 && k < r + 8) e[(s + 2) % 4] = 1'b1;
    return e;
  endfunction

  task automatic reset_dut(int n);
    rst      = 1'b1;
    bus.echo = '0;
    repeat (n) begin
      @(posedge clk);
      exp_trig = '0;
      exp_to   = '0;
      exp_done = 1'b0;
      for (int i = 0; i < 4; i++) exp_dist[i] = int'(DIST_MAX);
      cmp_en = 1;
      @(negedge clk);
    end
    check("rst_dist_literal", {bus.fd1, bus.fd2, bus.ld, bus.rd}, {4{12'hFFF}});
    rst = 1'b0;
  endtask

  // Cycle 0 is the first clock edge after reset is released.
  task automatic run_phase(input slot_t plan[$]);
    int t;
    t = TRIG_US;
    foreach (plan[i]) begin
      slot_t sl;
      int    s, st;
      bit    aborted;
      sl      = plan[i];
      s       = i % 4;
      st      = store_cycle(sl, t);
      aborted = 0;
      for (int k = t - TRIG_US; k <= st + GAP_US && !aborted; k++) begin
        @(posedge clk);
        exp_trig = (k < t) ? (4'b0001 << s) : 4'b0000;
        if (k == st) begin
          exp_dist[s] = expected_cm(sl);
          exp_to[s]   = slot_timed_out(sl);
        end
        exp_done = (k == st + 1) && (s == 3);
        @(negedge clk);
        bus.echo = echo_for(sl, s, t, k);
        if (k == st + 1 && sl.lit_cm >= 0) check("dist_literal", dist_port(s), sl.lit_cm);
        if (k == st + 1 && sl.lit_to >= 0) check("timeout_literal", bus.timeout[s], sl.lit_to);
        if (sl.rst_at > 0 && k == t + sl.rst_at) aborted = 1;
      end
      if (aborted) begin
        reset_dut(2);
        return;
      end
      t = st + GAP_US + TRIG_US + 1;
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("trig", bus.trig, exp_trig);
      check("trig_onehot", 64'($countones(bus.trig) > 1), 0);
      check("fd1", bus.fd1, exp_dist[0]);
      check("fd2", bus.fd2, exp_dist[1]);
      check("ld", bus.ld, exp_dist[2]);
      check("rd", bus.rd, exp_dist[3]);
      check("timeout", bus.timeout, exp_to);
      check("scan_done", bus.scan_done, exp_done);
    end
  end

  initial begin
    slot_t plan1[$];
    slot_t plan2[$];
    bus.echo = '0;
    reset_dut(3);

    plan1.push_back(mk(K_PULSE, 20, 5800, 0, 0, 0, 100, 0));
    plan1.push_back(mk(K_NONE, 50, 0, 0, 1, 0, 4095, 1));
    plan1.push_back(mk(K_PULSE, 7, 57, 0, 1, 0, 0, 0));
    plan1.push_back(mk(K_PULSE, 3, 59, 0, 0, 0, 1, 0));
    plan1.push_back(mk(K_PULSE, 30, 1160, 0, 0, 0, 20, 0));
    plan1.push_back(mk(K_PULSE, 30, 2900, 0, 1, 0, 50, 0));
    plan1.push_back(mk(K_PULSE, 200, 5800, 1, 0, 0, 100, 0));
    plan1.push_back(mk(K_PULSE, 30, 11600, 0, 0, 0, 200, 0));
    plan1.push_back(mk(K_HOLD, 40, 0, 0, 0, 0, 4095, 1));
    plan1.push_back(rnd_slot());
    plan1.push_back(mk(K_PULSE, 25, 5800, 0, 0, 25 + 4 + 2000, -1, -1));
    run_phase(plan1);

    for (int i = 0; i < 5; i++) plan2.push_back(rnd_slot());
    run_phase(plan2);

    finish_run();
  end

endmodule
